// File: rtl/fifo_ctrl.sv
// fifo_ctrl: circular-buffer controller for an external dual-port RAM with registered status and sticky error flags.
// Define FIFO_CTRL_ALMOST_EN to add registered almost_full/almost_empty outputs.
module fifo_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH = 16
`ifdef FIFO_CTRL_ALMOST_EN
    ,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
`ifdef FIFO_CTRL_ALMOST_EN
    output logic                  almost_full,
    output logic                  almost_empty,
`endif
    output logic                  underflow
);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, underflow_q, rd_valid_q;

    assign full        = count_q == FULL_CNT;
    assign empty       = count_q == '0;
    assign ram_wr_en   = push & ~full & ~rst;
    assign ram_rd_en   = pop & ~empty & ~rst;
    assign ram_wr_addr = wr_ptr_q;
    assign ram_rd_addr = rd_ptr_q;
    assign rd_valid    = rd_valid_q;
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

    // Wrap by explicit compare so non-power-of-2 depths never touch addresses >= DEPTH.
    always_comb begin
        wr_ptr_d = ram_wr_en ? (wr_ptr_q == LAST ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = ram_rd_en ? (rd_ptr_q == LAST ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
        count_d  = (ram_wr_en & ~ram_rd_en) ? count_q + 1'b1 :
                   (ram_rd_en & ~ram_wr_en) ? count_q - 1'b1 : count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_q | (push & full);
            underflow_q <= underflow_q | (pop & empty);
            rd_valid_q  <= ram_rd_en;
        end
    end

`ifdef FIFO_CTRL_ALMOST_EN
    localparam logic [ADDR_WIDTH:0] AF_CNT = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_CNT = (ADDR_WIDTH + 1)'(AE_LEVEL);

    logic almost_full_q, almost_empty_q;

    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            almost_full_q  <= count_d >= AF_CNT;
            almost_empty_q <= count_d <= AE_CNT;
        end
    end
`endif
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: scoreboard bench for fifo_ctrl at DEPTH=16 plus a DEPTH=12 instance for wrap checks.
module tb_fifo_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push = 1'b0, pop = 1'b0;
    logic [7:0] wr_data = '0, rd_data = '0;
    logic       ram_wr_en, ram_rd_en, rd_valid, full, empty, overflow, underflow;
    logic [3:0] ram_wr_addr, ram_rd_addr;
    logic [4:0] count;
    logic       push12 = 1'b0, pop12 = 1'b0;
    logic [7:0] wr_data12 = '0, rd_data12 = '0;
    logic       ram_wr_en12, ram_rd_en12, rd_valid12, full12, empty12, overflow12, underflow12;
    logic [3:0] ram_wr_addr12, ram_rd_addr12;
    logic [4:0] count12;
`ifdef FIFO_CTRL_ALMOST_EN
    logic       almost_full, almost_empty, almost_full12, almost_empty12;
`endif
    logic [7:0] mem [16];
    logic [7:0] mem12 [16];
    int         checks = 0, failures = 0, n_reads = 0;
    logic       mon_en = 1'b0;
    logic [4:0] m_cnt = '0;
    logic [3:0] m_wp = '0, m_rp = '0;
    logic       m_ov = 1'b0, m_un = 1'b0, m_rv = 1'b0;
    logic [7:0] m_exp = '0;
    logic [7:0] sb [$];

    always #5 clk = ~clk;

    fifo_ctrl u_dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
        .rd_valid(rd_valid), .full(full), .empty(empty), .count(count), .overflow(overflow),
`ifdef FIFO_CTRL_ALMOST_EN
        .almost_full(almost_full), .almost_empty(almost_empty),
`endif
        .underflow(underflow)
    );

    fifo_ctrl #(.ADDR_WIDTH(4), .DEPTH(12)) u_dut12 (
        .clk(clk), .rst(rst), .push(push12), .pop(pop12),
        .ram_wr_en(ram_wr_en12), .ram_wr_addr(ram_wr_addr12), .ram_rd_en(ram_rd_en12), .ram_rd_addr(ram_rd_addr12),
        .rd_valid(rd_valid12), .full(full12), .empty(empty12), .count(count12), .overflow(overflow12),
`ifdef FIFO_CTRL_ALMOST_EN
        .almost_full(almost_full12), .almost_empty(almost_empty12),
`endif
        .underflow(underflow12)
    );

    // Behavioural dual-port RAMs with registered read data.
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= wr_data;
        if (ram_rd_en) rd_data <= mem[ram_rd_addr];
        if (ram_wr_en12) mem12[ram_wr_addr12] <= wr_data12;
        if (ram_rd_en12) rd_data12 <= mem12[ram_rd_addr12];
    end

    // Reference FIFO model for the 16-deep instance; accepted pushes feed the scoreboard queue.
    always @(posedge clk) begin
        logic aw, ar;
        if (rst) begin
            m_cnt = '0; m_wp = '0; m_rp = '0; m_ov = 1'b0; m_un = 1'b0; m_rv = 1'b0;
            sb.delete();
        end else begin
            aw = push && m_cnt != 5'd16;
            ar = pop && m_cnt != 5'd0;
            if (push && m_cnt == 5'd16) m_ov = 1'b1;
            if (pop && m_cnt == 5'd0) m_un = 1'b1;
            if (aw) begin sb.push_back(wr_data); m_wp = m_wp + 4'd1; end
            if (ar) begin m_exp = sb.pop_front(); m_rp = m_rp + 4'd1; end
            m_rv = ar;
            m_cnt = m_cnt + 5'(aw) - 5'(ar);
        end
    end

    always @(negedge clk) begin
        logic exp_we, exp_re;
        if (mon_en) begin
            exp_we = push && !rst && m_cnt != 5'd16;
            exp_re = pop && !rst && m_cnt != 5'd0;
            checks += 10;
            if (ram_wr_en !== exp_we) begin failures++; $display("FAIL sb_wr_en got=%b exp=%b t=%0t", ram_wr_en, exp_we, $time); end
            if (ram_rd_en !== exp_re) begin failures++; $display("FAIL sb_rd_en got=%b exp=%b t=%0t", ram_rd_en, exp_re, $time); end
            if (count !== m_cnt) begin failures++; $display("FAIL sb_count got=%0d exp=%0d t=%0t", count, m_cnt, $time); end
            if (ram_wr_addr !== m_wp) begin failures++; $display("FAIL sb_wr_addr got=%0d exp=%0d t=%0t", ram_wr_addr, m_wp, $time); end
            if (ram_rd_addr !== m_rp) begin failures++; $display("FAIL sb_rd_addr got=%0d exp=%0d t=%0t", ram_rd_addr, m_rp, $time); end
            if (rd_valid !== m_rv) begin failures++; $display("FAIL sb_rd_valid got=%b exp=%b t=%0t", rd_valid, m_rv, $time); end
            if (full !== (m_cnt == 5'd16)) begin failures++; $display("FAIL sb_full got=%b cnt=%0d t=%0t", full, m_cnt, $time); end
            if (empty !== (m_cnt == 5'd0)) begin failures++; $display("FAIL sb_empty got=%b cnt=%0d t=%0t", empty, m_cnt, $time); end
            if (overflow !== m_ov) begin failures++; $display("FAIL sb_overflow got=%b exp=%b t=%0t", overflow, m_ov, $time); end
            if (underflow !== m_un) begin failures++; $display("FAIL sb_underflow got=%b exp=%b t=%0t", underflow, m_un, $time); end
            if (m_rv) begin
                checks++;
                n_reads++;
                if (rd_data !== m_exp) begin failures++; $display("FAIL sb_rd_data got=%0d exp=%0d t=%0t", rd_data, m_exp, $time); end
            end
`ifdef FIFO_CTRL_ALMOST_EN
            checks += 2;
            if (almost_full !== (m_cnt >= 5'd14)) begin failures++; $display("FAIL sb_almost_full got=%b cnt=%0d", almost_full, m_cnt); end
            if (almost_empty !== (m_cnt <= 5'd2)) begin failures++; $display("FAIL sb_almost_empty got=%b cnt=%0d", almost_empty, m_cnt); end
`endif
        end
    end

    task automatic step(input logic p, input logic q, input logic [7:0] d);
        push = p; pop = q; wr_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(0, 0, 8'h00);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1, 1, 8'hAA);
        mon_en = 1'b1;
        step(1, 1, 8'hAA);
        checks += 4;
        if (ram_wr_en !== 1'b0 || ram_rd_en !== 1'b0) begin failures++; $display("FAIL rst_en got=%b%b exp=00", ram_wr_en, ram_rd_en); end
        if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b exp=10", empty, full); end
        if (count !== 5'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
        if (rd_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL rst_misc got=%b%b%b exp=000", rd_valid, overflow, underflow); end
        rst = 1'b0; push = 1'b0; pop = 1'b1;
        #1;
        checks++;
        if (ram_rd_en !== 1'b0) begin failures++; $display("FAIL empty_pop_rd_en got=%b exp=0", ram_rd_en); end
        step(0, 1, 8'h00);
        checks += 3;
        if (underflow !== 1'b1) begin failures++; $display("FAIL empty_pop_underflow got=%b exp=1", underflow); end
        if (empty !== 1'b1 || count !== 5'd0) begin failures++; $display("FAIL empty_pop_state got=%b/%0d exp=1/0", empty, count); end
        if (rd_valid !== 1'b0) begin failures++; $display("FAIL empty_pop_rd_valid got=%b exp=0", rd_valid); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 16; i++) step(1, 0, 8'(i));
        checks += 3;
        if (full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", full); end
        if (count !== 5'd16) begin failures++; $display("FAIL fill_count got=%0d exp=16", count); end
        if (ram_wr_addr !== 4'd0) begin failures++; $display("FAIL fill_wr_addr got=%0d exp=0", ram_wr_addr); end
        push = 1'b1; wr_data = 8'h55;
        #1;
        checks++;
        if (ram_wr_en !== 1'b0) begin failures++; $display("FAIL fill_17th_wr_en got=%b exp=0", ram_wr_en); end
        step(1, 0, 8'h55);
        checks += 2;
        if (overflow !== 1'b1) begin failures++; $display("FAIL fill_overflow got=%b exp=1", overflow); end
        if (count !== 5'd16) begin failures++; $display("FAIL fill_17th_count got=%0d exp=16", count); end
    endtask

    task automatic test_drain();
        int n0;
        n0 = n_reads;
        for (int i = 0; i < 16; i++) step(0, 1, 8'h00);
        checks++;
        if (empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", empty); end
        step(0, 0, 8'h00);
        checks++;
        if (n_reads - n0 !== 16) begin failures++; $display("FAIL drain_reads got=%0d exp=16", n_reads - n0); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 8'(100 + i));
        for (int i = 0; i < 10; i++) step(1, 1, 8'(110 + i));
        checks += 2;
        if (count !== 5'd5) begin failures++; $display("FAIL simul_count got=%0d exp=5", count); end
        if (ram_wr_addr !== 4'd15 || ram_rd_addr !== 4'd10) begin failures++; $display("FAIL simul_ptrs got=%0d/%0d exp=15/10", ram_wr_addr, ram_rd_addr); end
        for (int i = 0; i < 11; i++) step(1, 0, 8'(120 + i));
        step(1, 1, 8'hEE);
        checks += 2;
        if (count !== 5'd15) begin failures++; $display("FAIL simul_full_count got=%0d exp=15", count); end
        if (overflow !== 1'b1) begin failures++; $display("FAIL simul_full_overflow got=%b exp=1", overflow); end
        do_reset();
        step(1, 1, 8'h77);
        checks += 2;
        if (count !== 5'd1) begin failures++; $display("FAIL simul_empty_count got=%0d exp=1", count); end
        if (underflow !== 1'b1) begin failures++; $display("FAIL simul_empty_underflow got=%b exp=1", underflow); end
        step(0, 1, 8'h00);
        step(0, 0, 8'h00);
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 14; i++) begin
            step(1, 0, 8'(50 + i));
`ifdef FIFO_CTRL_ALMOST_EN
            checks++;
            if (almost_full !== (i == 13)) begin failures++; $display("FAIL almost_full_at_%0d got=%b", i + 1, almost_full); end
`endif
        end
        rst = 1'b1;
        step(0, 1, 8'h00);
        rst = 1'b0;
        checks += 2;
        if (count !== 5'd0 || empty !== 1'b1) begin failures++; $display("FAIL midrst_state got=%0d/%b exp=0/1", count, empty); end
        if (rd_valid !== 1'b0) begin failures++; $display("FAIL midrst_rd_valid got=%b exp=0", rd_valid); end
`ifdef FIFO_CTRL_ALMOST_EN
        checks++;
        if (almost_empty !== 1'b1) begin failures++; $display("FAIL midrst_almost_empty got=%b exp=1", almost_empty); end
`endif
        for (int i = 0; i < 3; i++) step(1, 0, 8'(60 + i));
        step(0, 1, 8'h00);
        rst = 1'b1;
        step(0, 0, 8'h00);
        rst = 1'b0;
        checks++;
        if (rd_valid !== 1'b0) begin failures++; $display("FAIL midrst_pending_rd_valid got=%b exp=0", rd_valid); end
    endtask

    task automatic test_depth12();
        logic [3:0] ewp, erp;
        int         ecnt, wraps;
        logic       erv, aw, ar, q;
        logic [7:0] eexp;
        logic [7:0] q12 [$];
        ewp = '0; erp = '0; ecnt = 0; wraps = 0; erv = 1'b0; eexp = '0;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            q = (i % 3) != 0;
            push12 = 1'b1; pop12 = q; wr_data12 = 8'(200 + i);
            #1;
            checks += 3;
            if (ram_wr_addr12 !== ewp || ram_wr_addr12 >= 4'd12) begin failures++; $display("FAIL d12_wr_addr got=%0d exp=%0d", ram_wr_addr12, ewp); end
            if (ram_rd_addr12 !== erp || ram_rd_addr12 >= 4'd12) begin failures++; $display("FAIL d12_rd_addr got=%0d exp=%0d", ram_rd_addr12, erp); end
            if (rd_valid12 !== erv) begin failures++; $display("FAIL d12_rd_valid got=%b exp=%b", rd_valid12, erv); end
            if (erv) begin
                checks++;
                if (rd_data12 !== eexp) begin failures++; $display("FAIL d12_rd_data got=%0d exp=%0d", rd_data12, eexp); end
            end
            aw = ecnt < 12;
            ar = q && ecnt > 0;
            if (aw) begin q12.push_back(wr_data12); if (ewp == 4'd11) wraps++; ewp = (ewp == 4'd11) ? 4'd0 : ewp + 4'd1; end
            if (ar) begin eexp = q12.pop_front(); erp = (erp == 4'd11) ? 4'd0 : erp + 4'd1; end
            erv = ar;
            ecnt = ecnt + int'(aw) - int'(ar);
            @(posedge clk);
            #1;
        end
        push12 = 1'b0; pop12 = 1'b0;
        checks += 2;
        if (wraps !== 2 || ram_wr_addr12 !== 4'd6) begin failures++; $display("FAIL d12_wrap got=%0d/%0d exp=2/6", wraps, ram_wr_addr12); end
        if (count12 !== 5'(ecnt)) begin failures++; $display("FAIL d12_count got=%0d exp=%0d", count12, ecnt); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_mid_reset();
        test_depth12();
        step(0, 0, 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
